// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer
//   Walks the codec power-up register table and issues one 16-bit write per
//   entry over the shared I2C write master (xfer_req/xfer_done handshake).
//   NACKed or timed-out writes are retried up to MAX_RETRIES times. Every
//   transaction is followed by a GAP_CYCLES settle gap.
//
//   Optional build macro: CFG_SOFT_RESET_EN. When defined, a codec soft-reset
//   write (16'h1E00) goes out before the table. It is reported as reg_index 0.
//
// Ports
//   clk, reset    : clock, asynchronous active-high reset
//   start         : one-cycle pulse, starts/restarts from IDLE, DONE or ERROR
//   xfer_req      : one-cycle write request, xfer_word holds {addr[6:0], data[8:0]}
//   xfer_done     : transfer complete pulse, xfer_nack valid with it
//   busy          : sequence in progress
//   config_done   : table written successfully (level)
//   config_error  : retries exhausted (level)
//   reg_index     : table entry currently being written
//   retry_count   : retries used on the current entry
module codec_config_sequencer #(
  parameter int NUM_REGS       = 10,
  parameter int MAX_RETRIES    = 3,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        xfer_req,
  output logic [15:0] xfer_word,
  input  logic        xfer_done,
  input  logic        xfer_nack,
  output logic        busy,
  output logic        config_done,
  output logic        config_error,
  output logic [3:0]  reg_index,
  output logic [2:0]  retry_count
);

  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);
  localparam logic [15:0]      SOFT_RESET_WORD = 16'h1E00;

`ifdef CFG_SOFT_RESET_EN
  localparam logic SOFT_EN = 1'b1;
`else
  localparam logic SOFT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic [3:0]       idx_q, idx_d;
  logic [2:0]       retry_q, retry_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ok_q, ok_d;      // last attempt was acknowledged
  logic             soft_q, soft_d;  // soft-reset write pending/in flight

  function automatic logic [15:0] table_word(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'h1201;
      4'd1:    w = 16'h0017;
      4'd2:    w = 16'h0217;
      4'd3:    w = 16'h047F;
      4'd4:    w = 16'h067F;
      4'd5:    w = 16'h0812;
      4'd6:    w = 16'h0A00;
      4'd7:    w = 16'h0C02;
      4'd8:    w = 16'h0E23;
      4'd9:    w = 16'h1001;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      ok_q    <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      ok_q    <= ok_d;
      soft_q  <= soft_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    to_d    = to_q;
    gap_d   = gap_q;
    ok_d    = ok_q;
    soft_d  = soft_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          retry_d = '0;
          soft_d  = SOFT_EN;
        end
      end

      S_LOAD: begin
        word_d  = soft_q ? SOFT_RESET_WORD : table_word(idx_q);
        to_d    = '0;
        state_d = S_REQ;
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        gap_d = '0;
        // xfer_done is tested first so it wins over a coincident timeout.
        if (xfer_done && !xfer_nack) begin
          ok_d    = 1'b1;
          retry_d = '0;
          state_d = S_GAP;
        end else if (xfer_done || (to_q == TO_LAST)) begin
          ok_d = 1'b0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            state_d = S_GAP;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (!ok_q) begin
            state_d = S_LOAD;
          end else if (soft_q) begin
            // Soft-reset write done: table starts at index 0, which idx_q already holds.
            soft_d  = 1'b0;
            state_d = S_LOAD;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign xfer_req     = (state_q == S_REQ);
  assign busy         = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign config_done  = (state_q == S_DONE);
  assign config_error = (state_q == S_ERROR);
  assign xfer_word    = word_q;
  assign reg_index    = idx_q;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
module tb_codec_config_sequencer;

  localparam int NUM_REGS       = 10;
  localparam int MAX_RETRIES    = 3;
  localparam int GAP_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 4096;
`ifdef CFG_SOFT_RESET_EN
  localparam int SOFT = 1;
`else
  localparam int SOFT = 0;
`endif
  localparam logic [15:0] FIRST_WORD = (SOFT == 1) ? 16'h1E00 : 16'h1201;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        xfer_req;
  logic [15:0] xfer_word;
  logic        xfer_done;
  logic        xfer_nack;
  logic        busy;
  logic        config_done;
  logic        config_error;
  logic [3:0]  reg_index;
  logic [2:0]  retry_count;

  always #5 clk = ~clk;

  codec_config_sequencer #(
    .NUM_REGS       (NUM_REGS),
    .MAX_RETRIES    (MAX_RETRIES),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .xfer_req     (xfer_req),
    .xfer_word    (xfer_word),
    .xfer_done    (xfer_done),
    .xfer_nack    (xfer_nack),
    .busy         (busy),
    .config_done  (config_done),
    .config_error (config_error),
    .reg_index    (reg_index),
    .retry_count  (retry_count)
  );

  typedef struct {
    logic [15:0] word;
    logic [3:0]  idx;
    logic [2:0]  retry;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [15:0] tbl [0:9] = '{16'h1201, 16'h0017, 16'h0217, 16'h047F, 16'h067F,
                             16'h0812, 16'h0A00, 16'h0C02, 16'h0E23, 16'h1001};

  int n_tests = 0;
  int n_fail  = 0;

  bit          exp_err;
  int          exp_idx;
  int          exp_retry;
  logic [15:0] nack_word = 16'h0000;
  int          nack_left = 0;
  bit          resp_en   = 1'b1;
  bit          stray     = 1'b0;
  int          req_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: list every write the sequencer must issue for a
  // given slave behaviour, and the final outcome.
  task automatic build_model(input logic [15:0] nword, input int ncnt, input bit tmo_all);
    xfer_t e;
    int    nleft;
    bool_loop: begin
      exp_q.delete();
      for (int n = 0; n < NUM_REGS + SOFT; n++) begin
        if (SOFT == 1 && n == 0) begin
          e.word = 16'h1E00;
          e.idx  = 4'd0;
        end else begin
          e.word = tbl[n - SOFT];
          e.idx  = 4'(n - SOFT);
        end
        nleft = (e.word == nword) ? ncnt : 0;
        for (int a = 0; a <= MAX_RETRIES; a++) begin
          e.retry = 3'(a);
          exp_q.push_back(e);
          if (!(tmo_all || a < nleft)) break;
          if (a == MAX_RETRIES) begin
            exp_err   = 1'b1;
            exp_idx   = e.idx;
            exp_retry = MAX_RETRIES;
            disable bool_loop;
          end
        end
      end
      exp_err   = 1'b0;
      exp_idx   = NUM_REGS - 1;
      exp_retry = 0;
    end
  endtask

  // I2C master stand-in: answers each request 8 cycles later.
  initial begin : responder
    int pend;
    bit nack_this;
    pend      = 0;
    nack_this = 1'b0;
    xfer_done = 1'b0;
    xfer_nack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      xfer_done = 1'b0;
      xfer_nack = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            xfer_done = 1'b1;
            xfer_nack = nack_this;
          end
        end
        if (stray) begin
          xfer_done = 1'b1;
          xfer_nack = 1'b0;
        end
        if (xfer_req && resp_en) begin
          pend      = 8;
          nack_this = (xfer_word == nack_word) && (nack_left > 0);
          if (nack_this) nack_left--;
        end
      end
    end
  end

  // Compare process: every request against the model, plus per-cycle invariants.
  initial begin : monitor
    int          cyc_no;
    int          last_cyc;
    bit          have_last;
    bit          prev_req;
    bit          in_flight;
    logic [15:0] cur_word;
    xfer_t       e;
    cyc_no    = 0;
    last_cyc  = 0;
    have_last = 1'b0;
    prev_req  = 1'b0;
    in_flight = 1'b0;
    cur_word  = '0;
    forever begin
      @(posedge clk);
      #3;
      cyc_no++;
      if (reset) begin
        exp_q.delete();
        have_last = 1'b0;
        prev_req  = 1'b0;
        in_flight = 1'b0;
      end else begin
        chk("done_err_exclusive", {31'd0, config_done && config_error}, 0);
        if (!busy) in_flight = 1'b0;
        if (in_flight) chk("word_stable", xfer_word, cur_word);
        if (xfer_req) begin
          req_count++;
          chk("req_while_busy", busy, 1);
          chk("req_single_cycle", prev_req, 0);
          if (have_last)
            chk("req_spacing", {31'd0, (cyc_no - last_cyc) >= GAP_CYCLES + 2}, 1);
          have_last = 1'b1;
          last_cyc  = cyc_no;
          if (exp_q.size() == 0) begin
            chk("unexpected_req", xfer_word, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("req_word", xfer_word, e.word);
            chk("req_index", reg_index, e.idx);
            chk("req_retry", retry_count, e.retry);
            cur_word  = e.word;
            in_flight = 1'b1;
          end
        end
        if (xfer_done) in_flight = 1'b0;
        prev_req = xfer_req;
      end
    end
  end

  task automatic run_seq(input logic [15:0] nword, input int ncnt, input bit resp,
                         input bit mid_start, input int exp_reqs);
    bit finished;
    build_model(nword, ncnt, !resp);
    nack_word = nword;
    nack_left = ncnt;
    resp_en   = resp;
    req_count = 0;
    start = 1'b1;
    cyc;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_low", config_done, 0);
    chk("start_err_low", config_error, 0);
    chk("latency_no_req_in_load", xfer_req, 0);
    cyc;
    chk("latency_req_third_cycle", xfer_req, 1);
    chk("first_word", xfer_word, FIRST_WORD);
    finished = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      cyc;
      start = mid_start && (i == 30);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("sequence_finished", finished, 1);
    repeat (20) cyc;
    chk("req_total", req_count, exp_reqs);
    chk("model_drained", exp_q.size(), 0);
    chk("final_config_done", config_done, exp_err ? 0 : 1);
    chk("final_config_error", config_error, exp_err ? 1 : 0);
    chk("final_busy", busy, 0);
    chk("final_reg_index", reg_index, exp_idx);
    chk("final_retry_count", retry_count, exp_retry);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_xfer_req"}, xfer_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_config_done"}, config_done, 0);
    chk({tag, "_config_error"}, config_error, 0);
    chk({tag, "_xfer_word"}, xfer_word, 16'h0000);
    chk({tag, "_reg_index"}, reg_index, 0);
    chk({tag, "_retry_count"}, retry_count, 0);
  endtask

  initial begin : main
    bit found;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) cyc;
    chk_reset_values("por");
    reset = 1'b0;
    cyc;
    chk_reset_values("idle");

    // Clean run: all writes acknowledged.
    run_seq(16'h0000, 0, 1'b1, 1'b0, NUM_REGS + SOFT);

    // Stray xfer_done while in DONE must not disturb anything.
    stray = 1'b1;
    cyc;
    cyc;
    stray = 1'b0;
    cyc;
    cyc;
    chk("stray_done_still_done", config_done, 1);
    chk("stray_done_not_busy", busy, 0);

    // One NACK at index 3, acknowledged on retry.
    run_seq(16'h047F, 1, 1'b1, 1'b0, NUM_REGS + SOFT + 1);

    // Persistent NACK at index 5.
    run_seq(16'h0812, 99, 1'b1, 1'b0, SOFT + 5 + 4);
    chk("nack_err_word", xfer_word, 16'h0812);
    chk("nack_err_index", reg_index, 5);
    chk("nack_err_retry", retry_count, 3);

    // No response at all: every attempt times out (started from ERROR).
    run_seq(16'h0000, 0, 1'b0, 1'b0, 4);
    chk("tmo_err_index", reg_index, 0);
    chk("tmo_err_word", xfer_word, FIRST_WORD);

    // Reset during WAIT at index 6.
    build_model(16'h0000, 0, 1'b0);
    resp_en   = 1'b1;
    nack_left = 0;
    start = 1'b1;
    cyc;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc;
      if (xfer_req && reg_index == 4'd6) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_index6", found, 1);
    cyc;
    cyc;
    cyc;
    reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    cyc;
    cyc;
    reset = 1'b0;
    cyc;
    chk_reset_values("after_midreset");
    run_seq(16'h0000, 0, 1'b1, 1'b0, NUM_REGS + SOFT);

    // Restart from DONE, with an ignored start pulse while busy.
    run_seq(16'h0000, 0, 1'b1, 1'b1, NUM_REGS + SOFT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
Sequences the audio codec's power-up register configuration over the shared I2C write master. It walks a fixed 10-entry register table, issues one 16-bit write per entry through a req/done handshake, retries NACKed writes, and enforces a settle gap between writes. It asserts config_done, which gates the BCLK/LRCLK generators and the ADC-to-DAC loop-through; on an unrecoverable failure it asserts config_error.

Parameters:
NUM_REGS, 10, number of table entries written (1..15)
MAX_RETRIES, 3, extra attempts per entry after a NACK or timeout (0..7)
GAP_CYCLES, 16, idle clk cycles between consecutive transactions (>=1)
TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT before the attempt counts as failed

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins or restarts configuration from IDLE, DONE or ERROR
xfer_req  out  1  one-cycle pulse requesting an I2C write of xfer_word
xfer_word  out  16  [15:9] register address, [8:0] register data; held stable from REQ until WAIT exits
xfer_done  in  1  one-cycle pulse from the I2C master when a transfer completes
xfer_nack  in  1  sampled only when xfer_done=1; 1 means the slave did not acknowledge
busy  out  1  high in every state except IDLE, DONE and ERROR
config_done  out  1  level; high in DONE only
config_error  out  1  level; high in ERROR only
reg_index  out  4  table index currently being written
retry_count  out  3  retries used on the current entry

Behaviour:
- Reset values: state=IDLE; xfer_req, busy, config_done, config_error=0; xfer_word=16'h0000; reg_index=0; retry_count=0; gap and timeout counters=0.
- Table contents, indices 0..9: 1201, 0017, 0217, 047F, 067F, 0812, 0A00, 0C02, 0E23, 1001 (hex).
- IDLE: when start=1, go to LOAD with reg_index=0 and retry_count=0.
- LOAD: latch xfer_word = table[reg_index] and clear the timeout counter. Next state is REQ.
- REQ: xfer_req=1 for exactly this one cycle. Next state is WAIT.
- WAIT: increment the timeout counter each cycle.
  - If xfer_done=1 and xfer_nack=0: success. Clear retry_count and go to GAP.
  - If xfer_done=1 and xfer_nack=1, or the timeout counter reaches TIMEOUT_CYCLES-1, the attempt has failed:
    - If retry_count<MAX_RETRIES: increment retry_count and go to GAP, keeping reg_index so the same entry is re-sent.
    - Otherwise go to ERROR.
  - If xfer_done and the timeout fire in the same cycle, xfer_done takes precedence.
- GAP: wait GAP_CYCLES cycles.
  - If the last attempt succeeded and reg_index==NUM_REGS-1: go to DONE.
  - If the last attempt succeeded otherwise: increment reg_index, then go to LOAD.
  - If the last attempt failed: go to LOAD (retry of the same entry).
- DONE: hold config_done=1. start=1 restarts the sequence from index 0 (IDLE path) and config_done drops the next cycle.
- ERROR: hold config_error=1. reg_index and retry_count freeze at their failing values. start=1 restarts from index 0.
- A start pulse while busy=1 is ignored.
- A xfer_done pulse outside WAIT is ignored.
- Reset asserted mid-sequence returns all state and outputs to reset values immediately. xfer_req is never left high.
- Minimum latency from start to the first xfer_req: 3 cycles (IDLE→LOAD→REQ).

Optional Feature:
Macro CFG_SOFT_RESET_EN.
- When defined: a codec soft-reset write (16'h1E00) is sent first as a virtual index. reg_index reads 0 during it, and table entries follow at indices 0..NUM_REGS-1. The sequence performs NUM_REGS+1 transactions, and the soft-reset write follows the same retry and timeout rules.
- When undefined: only the NUM_REGS table writes are issued.

Test Plan:
1. Reset, then start pulse, with a model that returns xfer_done with nack=0 8 cycles after each xfer_req → 10 xfer_req pulses carrying 1201…1001 in table order, each pulse ≥GAP_CYCLES+2 cycles apart; then config_done=1, busy=0, config_error=0.
2. NACK on the first attempt at index 3, ACK afterwards → 047F sent twice; retry_count=1 during the second attempt, then 0; config_done asserts after 11 total requests.
3. NACK every attempt at index 5 → exactly 4 requests of 0812; then ERROR with config_error=1, reg_index=5, retry_count=3, and no further xfer_req.
4. Never return xfer_done → after TIMEOUT_CYCLES a retry is sent; after 4 attempts the block reaches ERROR with reg_index=0.
5. Assert reset during WAIT at index 6 → all outputs return to reset values the same cycle. A new start pulse begins again at 1201.
6. Start pulse in DONE → config_done falls and the full 10-write sequence repeats. A start pulse while busy produces no extra requests.
7. With CFG_SOFT_RESET_EN defined, repeat scenario 1 → first xfer_word is 1E00, followed by the 10 table writes; 11 requests total before config_done.
